// File: rtl/axis_pkt_arbiter.sv
// Round-robin AXI-Stream packet arbiter: merges N input streams onto one output,
// holding each grant until the packet's tlast beat is accepted downstream.
`timescale 1ns/1ps
module axis_pkt_arbiter #(
    parameter int DW = 128,
    parameter int N  = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            enable,
    input  logic [N*DW-1:0] s_axis_tdata,
    input  logic [N-1:0]    s_axis_tvalid,
    input  logic [N-1:0]    s_axis_tlast,
    output logic [N-1:0]    s_axis_tready,
    output logic [DW-1:0]   m_axis_tdata,
    output logic            m_axis_tvalid,
    output logic            m_axis_tlast,
    input  logic            m_axis_tready,
    output logic [2:0]      grant_id,
    output logic            busy,
    output logic [15:0]     pkt_count
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_grant;
    logic [2:0]  r_last_grant;
    logic [15:0] r_pkt_count;

    logic [DW-1:0] w_tdata [N];
    logic          w_win_found;
    logic [2:0]    w_win_idx;
    logic          w_arb;
    logic          w_beat;
    logic          w_pkt_done;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign w_tdata[gi] = s_axis_tdata[gi*DW +: DW];
        end
    endgenerate

    // Priority search starts just above the previous winner and wraps modulo N.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = 3'd0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_win_found && (i == (int'(r_last_grant) + k) % N) && s_axis_tvalid[i]) begin
                    w_win_found = 1'b1;
                    w_win_idx   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (r_state == XFER) begin
            for (int i = 0; i < N; i++) begin
                if (r_grant == 3'(i)) begin
                    m_axis_tdata     = w_tdata[i];
                    m_axis_tvalid    = s_axis_tvalid[i];
                    m_axis_tlast     = s_axis_tlast[i];
                    s_axis_tready[i] = m_axis_tready;
                end
            end
        end
    end

    assign w_arb      = (r_state == IDLE) && enable && w_win_found;
    assign w_beat     = (r_state == XFER) && m_axis_tvalid && m_axis_tready;
    assign w_pkt_done = w_beat && m_axis_tlast;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_arb)      w_state_next = XFER;
            XFER:    if (w_pkt_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // last_grant resets to N-1 so stream 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_grant      <= 3'd0;
            r_last_grant <= 3'(N-1);
            r_pkt_count  <= 16'd0;
        end else begin
            if (w_arb) begin
                r_grant <= w_win_idx;
            end
            if (w_pkt_done) begin
                r_last_grant <= r_grant;
                r_pkt_count  <= r_pkt_count + 16'd1;
            end
        end
    end

    assign grant_id  = (r_state == XFER) ? r_grant : 3'd0;
    assign busy      = (r_state == XFER);
    assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Scoreboard bench for axis_pkt_arbiter: per-stream source queues feed the DUT and
// every accepted output beat is matched against the expected stream/data/last.
`timescale 1ns/1ps
module tb_axis_pkt_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            resetn;
    logic            enable;
    logic [N*DW-1:0] s_axis_tdata;
    logic [N-1:0]    s_axis_tvalid;
    logic [N-1:0]    s_axis_tlast;
    logic [N-1:0]    s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tready;
    logic [2:0]      grant_id;
    logic            busy;
    logic [15:0]     pkt_count;

    typedef struct packed {
        logic [2:0]    sid;
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    exp_t        sb_q [$];
    logic [DW:0] src_q [N][$];
    logic [N-1:0] consume = '0;
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_pkt  = 16'd0;

    always #5 clk = ~clk;

    axis_pkt_arbiter #(.DW(DW), .N(N)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .grant_id      (grant_id),
        .busy          (busy),
        .pkt_count     (pkt_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int s, input int tag, input int b);
        return {8'(tag), 8'(s), 16'(b)};
    endfunction

    // Queues the packet at the source and records its beats as expected output.
    task automatic load_pkt(input int s, input int nbeats, input int tag);
        for (int b = 0; b < nbeats; b++) begin
            logic          lst;
            logic [DW-1:0] d;
            lst = (b == nbeats - 1);
            d   = beat_data(s, tag, b);
            src_q[s].push_back({lst, d});
            sb_q.push_back('{sid: 3'(s), last: lst, data: d});
        end
    endtask

    task automatic drive_heads();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                s_axis_tvalid[i]          = 1'b1;
                s_axis_tlast[i]           = src_q[i][0][DW];
                s_axis_tdata[i*DW +: DW]  = src_q[i][0][DW-1:0];
            end else begin
                s_axis_tvalid[i]          = 1'b0;
                s_axis_tlast[i]           = 1'b0;
                s_axis_tdata[i*DW +: DW]  = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (consume[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        drive_heads();
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) src_q[i].delete();
        sb_q.delete();
    endtask

    task automatic wait_pkts(input logic [15:0] target, input int budget, output int n, output int idle);
        n    = 0;
        idle = 0;
        do begin
            tick();
            @(negedge clk);
            n++;
            if (!busy) idle++;
        end while (pkt_count != target && n < budget);
        check("pkt_count", 64'(pkt_count), 64'(target));
    endtask

    // Handshakes are sampled mid-cycle; they complete on the following rising edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (resetn) begin
            consume <= s_axis_tvalid & s_axis_tready;
            if (m_axis_tvalid && m_axis_tready) begin
                $display("beat sid=%0d data=%08h last=%0d pkt_count=%0d", grant_id, m_axis_tdata, m_axis_tlast, pkt_count);
                if (sb_q.size() == 0) begin
                    check("sb_extra_beat", 64'({1'b1, m_axis_tdata}), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("beat_data", 64'(m_axis_tdata), 64'(e.data));
                    check("beat_last", 64'(m_axis_tlast), 64'(e.last));
                    check("beat_sid",  64'(grant_id),     64'(e.sid));
                end
            end
        end else begin
            consume <= '0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   idle;
        logic done;

        resetn        = 1'b0;
        enable        = 1'b0;
        m_axis_tready = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;

        repeat (3) tick();
        @(negedge clk);
        check("rst_busy",    64'(busy),          64'd0);
        check("rst_gid",     64'(grant_id),      64'd0);
        check("rst_pkt",     64'(pkt_count),     64'd0);
        check("rst_tvalid",  64'(m_axis_tvalid), 64'd0);
        check("rst_tready",  64'(s_axis_tready), 64'd0);
        tick();
        resetn        = 1'b1;
        enable        = 1'b1;
        m_axis_tready = 1'b1;

        // Round robin: four 3-beat packets, expected order 0,1,2,3.
        for (int s = 0; s < N; s++) load_pkt(s, 3, 1);
        exp_pkt = 16'd4;
        wait_pkts(exp_pkt, 40, n, idle);
        check("rr_cycles",     64'(n),           64'd17);
        check("rr_idle",       64'(idle),        64'd5);
        check("rr_sb_drained", 64'(sb_q.size()), 64'd0);

        // Backpressure on stream 2 with downstream ready toggling.
        load_pkt(2, 4, 2);
        exp_pkt = exp_pkt + 16'd1;
        tick();
        @(negedge clk);
        check("bp_idle_ready",  64'(s_axis_tready), 64'd0);
        check("bp_idle_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("bp_idle_busy",   64'(busy),          64'd0);
        tick();
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            m_axis_tready = (k % 2 == 0);
            @(negedge clk);
            check("bp_ready_mirror", 64'(s_axis_tready), 64'({m_axis_tready, 2'b00}));
            check("bp_gid",          64'(grant_id),      64'd2);
            done = m_axis_tvalid && m_axis_tready && m_axis_tlast;
            tick();
        end
        m_axis_tready = 1'b1;
        @(negedge clk);
        check("bp_pkt",        64'(pkt_count),   64'(exp_pkt));
        check("bp_busy_after", 64'(busy),        64'd0);
        check("bp_sb_drained", 64'(sb_q.size()), 64'd0);

        // Packet lock: stream 1 mid-packet while 0 and 3 request; next grants 3 then 0.
        load_pkt(1, 4, 3);
        tick();
        tick();
        tick();
        load_pkt(3, 2, 4);
        load_pkt(0, 2, 4);
        n = 0;
        do begin
            @(negedge clk);
            check("lock_gid", 64'(grant_id), 64'd1);
            tick();
            n++;
        end while (pkt_count == exp_pkt && n < 10);
        exp_pkt = exp_pkt + 16'd1;
        check("lock_pkt", 64'(pkt_count), 64'(exp_pkt));
        exp_pkt = exp_pkt + 16'd2;
        wait_pkts(exp_pkt, 20, n, idle);
        check("lock_sb_drained", 64'(sb_q.size()), 64'd0);

        // Enable drops on beat 2 of a 5-beat packet; packet must still complete.
        load_pkt(1, 5, 5);
        tick();
        tick();
        tick();
        enable = 1'b0;
        exp_pkt = exp_pkt + 16'd1;
        wait_pkts(exp_pkt, 20, n, idle);
        check("en_busy_after", 64'(busy), 64'd0);
        load_pkt(2, 1, 6);
        load_pkt(3, 1, 6);
        load_pkt(0, 1, 6);
        load_pkt(1, 1, 6);
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            check("en_hold_busy",   64'(busy),          64'd0);
            check("en_hold_tvalid", 64'(m_axis_tvalid), 64'd0);
        end
        enable = 1'b1;
        exp_pkt = exp_pkt + 16'd4;
        wait_pkts(exp_pkt, 40, n, idle);
        check("en_rr_cycles",    64'(n),           64'd8);
        check("en_sb_drained",   64'(sb_q.size()), 64'd0);

        // Reset during beat 3 of stream 2's packet.
        load_pkt(2, 5, 7);
        load_pkt(3, 5, 7);
        load_pkt(0, 5, 7);
        load_pkt(1, 5, 7);
        tick();
        tick();
        tick();
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        check("mid_rst_busy",   64'(busy),          64'd0);
        check("mid_rst_pkt",    64'(pkt_count),     64'd0);
        check("mid_rst_gid",    64'(grant_id),      64'd0);
        check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("mid_rst_tready", 64'(s_axis_tready), 64'd0);
        flush();
        for (int s = 0; s < N; s++) load_pkt(s, 2, 8);
        tick();
        @(negedge clk);
        check("mid_rst_first_gid", 64'(grant_id), 64'd0);
        exp_pkt = 16'd4;
        wait_pkts(exp_pkt, 40, n, idle);
        check("mid_rst_sb_drained", 64'(sb_q.size()), 64'd0);

        // Counter wrap: preload near the top so the wrap is reached in a few packets.
        force dut.r_pkt_count = 16'hFFFD;
        tick();
        release dut.r_pkt_count;
        @(negedge clk);
        check("wrap_preload", 64'(pkt_count), 64'hFFFD);
        exp_pkt = 16'hFFFD;
        for (int p = 0; p < 3; p++) begin
            load_pkt(0, 1, 9 + p);
            exp_pkt = exp_pkt + 16'd1;
            wait_pkts(exp_pkt, 10, n, idle);
            check("single_beat_cycles", 64'(n), 64'd3);
        end
        check("wrap_zero",        64'(pkt_count),   64'd0);
        check("final_sb_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_pkt_arbiter.md
AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

Interface
REQ-001 SHALL have parameter DW, default 128: data width of every stream.
REQ-002 SHALL have parameter N, default 4, legal range 2..8: number of input streams.
REQ-003 SHALL have port clk, input, 1 bit: clock, all logic on the rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port enable, input, 1 bit: permits new grants.
REQ-006 SHALL have port s_axis_tdata, input, N*DW bits: input data, stream i in bits [i*DW +: DW].
REQ-007 SHALL have port s_axis_tvalid, input, N bits: per-stream valid.
REQ-008 SHALL have port s_axis_tlast, input, N bits: per-stream end of packet.
REQ-009 SHALL have port s_axis_tready, output, N bits: per-stream ready.
REQ-010 SHALL have port m_axis_tdata, output, DW bits: merged output data.
REQ-011 SHALL have port m_axis_tvalid, output, 1 bit: output valid.
REQ-012 SHALL have port m_axis_tlast, output, 1 bit: output end of packet.
REQ-013 SHALL have port m_axis_tready, input, 1 bit: downstream ready.
REQ-014 SHALL have port grant_id, output, 3 bits: index of the stream currently granted; 0 when idle.
REQ-015 SHALL have port busy, output, 1 bit: high while in XFER.
REQ-016 SHALL have port pkt_count, output, 16 bits: count of completed packets.

Function
REQ-017 SHALL implement a two-state FSM with states IDLE and XFER.
REQ-018 SHALL arbitrate in IDLE only when enable=1 and at least one s_axis_tvalid bit is high.
- Winner: first valid index searching upward from last_grant+1, modulo N.
- Registers grant and enters XFER on the next edge.
REQ-019 SHALL apply one cycle of arbitration latency: IDLE asserts no s_axis_tready and m_axis_tvalid=0.
REQ-020 SHALL route the granted stream combinationally while in XFER.
- m_axis_tdata/tvalid/tlast = stream[grant].
- s_axis_tready[grant] = m_axis_tready; all other s_axis_tready bits = 0.
REQ-021 SHALL count a beat only when m_axis_tvalid and m_axis_tready are both high.
REQ-022 SHALL lock the grant for the whole packet: no switch until a beat with m_axis_tlast=1 is accepted.
REQ-023 SHALL, on acceptance of a tlast beat, on the same edge:
- set last_grant <= grant;
- increment pkt_count;
- return to IDLE.
Consequence: at least one idle cycle between packets.
REQ-024 SHALL hold state in XFER while the granted stream has tvalid=0 (bubble); the grant is not released.
REQ-025 SHALL complete a packet in progress when enable falls during XFER; enable only blocks arbitration in IDLE.
REQ-026 SHALL grant the same stream again when it is the only valid stream, regardless of last_grant.
REQ-027 SHALL wrap pkt_count from 0xFFFF to 0x0000 with no flag.
REQ-028 SHALL handle a single-beat packet (tlast on the first beat) as a full packet, with identical cycle behaviour.
REQ-029 SHALL not consume input data in IDLE: every s_axis_tready bit is 0 in IDLE.

Reset
REQ-030 SHALL, while resetn=0 at a rising edge, enter IDLE.
REQ-031 SHALL apply these reset values:
- last_grant = N-1, so stream 0 has first priority;
- grant_id = 0, busy = 0, pkt_count = 0;
- m_axis_tvalid = 0 and all s_axis_tready = 0.
REQ-032 SHALL abandon a packet on reset mid-packet, with no partial count; after reset the source re-presents from its own state.

Verification
REQ-033 Round-robin scenario:
- Stimulus: N=4, enable=1, streams 0..3 each hold one 3-beat packet, m_axis_tready=1.
- Required response: output order 0,1,2,3; pkt_count=4; one idle cycle between packets; each packet takes 4 cycles.
REQ-034 Backpressure scenario:
- Stimulus: stream 2 sends a 4-beat packet while m_axis_tready toggles 1,0,1,0,...
- Required response: data delivered in order with no loss or duplication; s_axis_tready[2] mirrors m_axis_tready; other ready bits stay 0.
REQ-035 Packet lock scenario:
- Stimulus: stream 1 is mid-packet when stream 0 asserts valid.
- Required response: stream 0 is not granted until stream 1's tlast beat is accepted; next grant is 2 if stream 2 is valid, otherwise 3, otherwise 0.
REQ-036 Enable scenario:
- Stimulus: enable falls on beat 2 of a 5-beat packet.
- Required response: the packet completes; pkt_count increments; FSM stays in IDLE while all-valid inputs are held.
REQ-037 Reset mid-packet scenario:
- Stimulus: resetn=0 for 1 cycle during beat 3.
- Required response: next cycle busy=0 and pkt_count=0; first grant afterwards is stream 0 when all streams are valid.
REQ-038 Wrap scenario:
- Stimulus: pkt_count preloaded by 65535 single-beat packets, then one more packet.
- Required response: pkt_count reads 0x0000.
